cache_controller: RTL and testbench



---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_ace_req_tracker.sv | 56 +++++
 rtl/cache_controller.sv | 163 ++++++++++++++++
 tb/tb_cache_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// cache_pkg: line-state and controller-state encodings shared by the cache controller.
// Rev 1.0
package cache_pkg;

  typedef enum logic [2:0] {
    LS_UC  = 3'b000,
    LS_UD  = 3'b001,
    LS_SC  = 3'b010,
    LS_SD  = 3'b011,
    LS_INV = 3'b100
  } line_state_e;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOOKUP    = 4'd1;
  localparam logic [3:0] ST_WB_REQ    = 4'd2;
  localparam logic [3:0] ST_RD_REQ    = 4'd3;
  localparam logic [3:0] ST_UPG_REQ   = 4'd4;
  localparam logic [3:0] ST_FILL      = 4'd5;
  localparam logic [3:0] ST_CPU_WRITE = 4'd6;
  localparam logic [3:0] ST_RESP      = 4'd7;
  localparam logic [3:0] ST_ERR_RESP  = 4'd8;
  localparam logic [3:0] ST_GAP       = 4'd9;

  function automatic logic is_dirty(input logic [2:0] ls);
    return (ls == LS_UD) || (ls == LS_SD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ace_req_tracker.sv
`default_nettype none
// cache_ace_req_tracker: retry and watchdog counters for one outstanding ACE request.
// Rev 1.0
module cache_ace_req_tracker #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic active,
  input  logic ace_done,
  input  logic ok,
  output logic retry,
  output logic abort,
  output logic timeout
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] wait_cnt;
  logic          fail;
  logic          wait_last;

  assign fail      = active && ace_done && !ok;
  assign abort     = fail && ((int'(retry_cnt) + 1) >= MAX_RETRY);
  assign retry     = fail && !abort;
  assign wait_last = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout   = active && !ace_done && wait_last;

  // Retry count spans the whole CPU transaction; only leaving to IDLE clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (clear) begin
      retry_cnt <= '0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear || start) begin
      wait_cnt <= '0;
    end else if (active && !wait_last) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// cache_controller: sequencing FSM between the CPU port, cache datapath and ACE controller.
// Rev 1.0
module cache_controller
  import cache_pkg::*;
#(
  parameter int WIDTH_STATE    = 3,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  output logic                   cpu_busy,
  output logic                   cpu_done,
  output logic                   cpu_err,
  input  logic                   cache_hit,
  input  logic                   cache_miss,
  input  logic [WIDTH_STATE-1:0] line_state,
  input  logic                   snoop_busy,
  output logic                   write_from_cpu,
  output logic                   write_from_interconnect,
  output logic [WIDTH_STATE-1:0] new_state,
  output logic                   mux_en,
  output logic                   read_resp_en,
  output logic                   write_clean,
  output logic                   read_shared,
  output logic                   make_unique,
  input  logic                   ace_done,
  input  logic                   B_okay,
  input  logic                   R_okay
);

  logic [3:0] state;
  logic [3:0] state_nx;
  logic [3:0] gap_ret;
  logic       wr_q;
  logic       hit;
  logic       in_req;
  logic       nx_req;
  logic       bus_ok;
  logic       start;
  logic       clear;
  logic       retry;
  logic       abort;
  logic       timeout;

  assign hit    = cache_hit && !cache_miss;
  assign in_req = (state == ST_WB_REQ) || (state == ST_RD_REQ) || (state == ST_UPG_REQ);
  assign nx_req = (state_nx == ST_WB_REQ) || (state_nx == ST_RD_REQ) || (state_nx == ST_UPG_REQ);
  assign bus_ok = (state == ST_WB_REQ) ? B_okay : R_okay;
  assign start  = nx_req && (state_nx != state);
  assign clear  = (state_nx == ST_IDLE);

  cache_ace_req_tracker #(
    .MAX_RETRY      (MAX_RETRY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .active   (in_req),
    .ace_done (ace_done),
    .ok       (bus_ok),
    .retry    (retry),
    .abort    (abort),
    .timeout  (timeout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (cpu_req) state_nx = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!snoop_busy) begin
          if (hit) begin
            if (!wr_q)                                        state_nx = ST_RESP;
            else if ((line_state == LS_UC) || (line_state == LS_UD)) state_nx = ST_CPU_WRITE;
            else                                              state_nx = ST_UPG_REQ;
          end else if (wr_q) begin
            // Whole single-word line is overwritten, so a dirty victim is dropped.
            state_nx = ST_UPG_REQ;
          end else if (is_dirty(line_state)) begin
            state_nx = ST_WB_REQ;
          end else begin
            state_nx = ST_RD_REQ;
          end
        end
      end
      ST_WB_REQ, ST_RD_REQ, ST_UPG_REQ: begin
        if (ace_done) begin
          if (bus_ok) begin
            if (state == ST_WB_REQ)      state_nx = ST_RD_REQ;
            else if (state == ST_RD_REQ) state_nx = ST_FILL;
            else                         state_nx = ST_CPU_WRITE;
          end else if (abort) begin
            state_nx = ST_ERR_RESP;
          end else if (retry) begin
            state_nx = ST_GAP;
          end
        end else if (timeout) begin
          state_nx = ST_ERR_RESP;
        end
      end
      ST_FILL, ST_CPU_WRITE: state_nx = ST_RESP;
      ST_RESP, ST_ERR_RESP:  state_nx = ST_IDLE;
      ST_GAP:                state_nx = gap_ret;
      default:               state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      gap_ret <= ST_IDLE;
    end else begin
      state <= state_nx;
      if ((state == ST_IDLE) && cpu_req) wr_q <= cpu_wr;
      if (state_nx == ST_GAP) gap_ret <= state;
    end
  end

  always_comb begin
    cpu_busy                = (state != ST_IDLE);
    cpu_done                = 1'b0;
    cpu_err                 = 1'b0;
    write_from_cpu          = 1'b0;
    write_from_interconnect = 1'b0;
    new_state               = '0;
    mux_en                  = 1'b0;
    read_resp_en            = 1'b0;
    write_clean             = 1'b0;
    read_shared             = 1'b0;
    make_unique             = 1'b0;
    case (state)
      ST_WB_REQ:  write_clean = 1'b1;
      ST_RD_REQ:  read_shared = 1'b1;
      ST_UPG_REQ: make_unique = 1'b1;
      ST_FILL: begin
        write_from_interconnect = 1'b1;
        read_resp_en            = 1'b1;
      end
      ST_CPU_WRITE: begin
        write_from_cpu = 1'b1;
        mux_en         = 1'b1;
        new_state      = WIDTH_STATE'(LS_UD);
      end
      ST_RESP: cpu_done = 1'b1;
      ST_ERR_RESP: begin
        cpu_done = 1'b1;
        cpu_err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// tb_cache_controller: directed self-checking bench for cache_controller.
// Rev 1.0
module tb_cache_controller;
  import cache_pkg::*;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       cpu_req    = 1'b0;
  logic       cpu_wr     = 1'b0;
  logic       cache_hit  = 1'b0;
  logic       cache_miss = 1'b1;
  logic [2:0] line_state = 3'b100;
  logic       snoop_busy = 1'b0;
  logic       ace_done   = 1'b0;
  logic       B_okay     = 1'b0;
  logic       R_okay     = 1'b0;

  logic       cpu_busy, cpu_done, cpu_err;
  logic       write_from_cpu, write_from_interconnect, mux_en, read_resp_en;
  logic       write_clean, read_shared, make_unique;
  logic [2:0] new_state;

  cache_controller dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cpu_req                 (cpu_req),
    .cpu_wr                  (cpu_wr),
    .cpu_busy                (cpu_busy),
    .cpu_done                (cpu_done),
    .cpu_err                 (cpu_err),
    .cache_hit               (cache_hit),
    .cache_miss              (cache_miss),
    .line_state              (line_state),
    .snoop_busy              (snoop_busy),
    .write_from_cpu          (write_from_cpu),
    .write_from_interconnect (write_from_interconnect),
    .new_state               (new_state),
    .mux_en                  (mux_en),
    .read_resp_en            (read_resp_en),
    .write_clean             (write_clean),
    .read_shared             (read_shared),
    .make_unique             (make_unique),
    .ace_done                (ace_done),
    .B_okay                  (B_okay),
    .R_okay                  (R_okay)
  );

  always #5 clk = ~clk;

  // {busy,done,err,wr_cpu,wr_ic,mux_en,rresp_en,write_clean,read_shared,make_unique,new_state[2:0]}
  logic [12:0] outs;
  assign outs = {cpu_busy, cpu_done, cpu_err, write_from_cpu, write_from_interconnect,
                 mux_en, read_resp_en, write_clean, read_shared, make_unique, new_state};

  localparam logic [12:0] O_IDLE   = 13'h0000;
  localparam logic [12:0] O_LOOKUP = 13'h1000;
  localparam logic [12:0] O_GAP    = 13'h1000;
  localparam logic [12:0] O_WB     = 13'h1020;
  localparam logic [12:0] O_RD     = 13'h1010;
  localparam logic [12:0] O_UPG    = 13'h1008;
  localparam logic [12:0] O_FILL   = 13'h1140;
  localparam logic [12:0] O_CPUWR  = 13'h1281;
  localparam logic [12:0] O_RESP   = 13'h1800;
  localparam logic [12:0] O_ERR    = 13'h1C00;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [12:0] exp);
    n_checks++;
    assert (outs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic h, input logic [2:0] st);
    cache_hit  = h;
    cache_miss = !h;
    line_state = st;
  endtask

  task automatic accept(input logic wr);
    cpu_wr  = wr;
    cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
  endtask

  task automatic pulse(input logic b, input logic r);
    B_okay   = b;
    R_okay   = r;
    ace_done = 1'b1;
    step();
    ace_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("reset_outputs", O_IDLE);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", O_IDLE);

    // Load hit on UC
    set_line(1'b1, 3'b000); accept(1'b0);
    chk("lh_lookup", O_LOOKUP); step();
    chk("lh_resp", O_RESP); step();
    chk("lh_idle", O_IDLE);

    // Store hit on UC
    set_line(1'b1, 3'b000); accept(1'b1);
    chk("sh_uc_lookup", O_LOOKUP); step();
    chk("sh_uc_cpuwr", O_CPUWR); step();
    chk("sh_uc_resp", O_RESP); step();
    chk("sh_uc_idle", O_IDLE);

    // Store hit on SC needs MakeUnique; B_okay low proves R_okay is used
    set_line(1'b1, 3'b010); accept(1'b1);
    chk("sh_sc_lookup", O_LOOKUP); step();
    chk("sh_sc_upg", O_UPG); step();
    chk("sh_sc_upg_hold", O_UPG);
    pulse(1'b0, 1'b1);
    chk("sh_sc_cpuwr", O_CPUWR); step();
    chk("sh_sc_resp", O_RESP); step();
    chk("sh_sc_idle", O_IDLE);

    // Store miss with dirty victim goes straight to MakeUnique
    set_line(1'b0, 3'b001); accept(1'b1);
    chk("sm_lookup", O_LOOKUP); step();
    chk("sm_upg", O_UPG);
    pulse(1'b0, 1'b1);
    chk("sm_cpuwr", O_CPUWR); step();
    chk("sm_resp", O_RESP); step();
    chk("sm_idle", O_IDLE);

    // Load miss, UD victim: WriteClean then ReadShared then fill
    set_line(1'b0, 3'b001); accept(1'b0);
    chk("lm_ud_lookup", O_LOOKUP); step();
    chk("lm_ud_wb", O_WB); step();
    chk("lm_ud_wb_hold", O_WB);
    pulse(1'b1, 1'b0);
    chk("lm_ud_rd", O_RD); step();
    chk("lm_ud_rd_hold", O_RD);
    pulse(1'b0, 1'b1);
    chk("lm_ud_fill", O_FILL); step();
    chk("lm_ud_resp", O_RESP); step();
    chk("lm_ud_idle", O_IDLE);

    // Load miss, SD victim is also dirty
    set_line(1'b0, 3'b011); accept(1'b0);
    step();
    chk("lm_sd_wb", O_WB);
    pulse(1'b1, 1'b0);
    chk("lm_sd_rd", O_RD);
    pulse(1'b0, 1'b1);
    chk("lm_sd_fill", O_FILL); step(); step();
    chk("lm_sd_idle", O_IDLE);

    // Two read failures then success: two GAPs, clean completion
    set_line(1'b0, 3'b000); accept(1'b0);
    step();
    chk("rt2_rd0", O_RD);
    pulse(1'b1, 1'b0);
    chk("rt2_gap0", O_GAP); step();
    chk("rt2_rd1", O_RD);
    pulse(1'b0, 1'b0);
    chk("rt2_gap1", O_GAP); step();
    chk("rt2_rd2", O_RD);
    pulse(1'b0, 1'b1);
    chk("rt2_fill", O_FILL); step();
    chk("rt2_resp", O_RESP); step();
    chk("rt2_idle", O_IDLE);

    // Three read failures abort; counter must have cleared after previous transaction
    set_line(1'b0, 3'b010); accept(1'b0);
    step();
    chk("rt3_rd0", O_RD);
    pulse(1'b0, 1'b0);
    chk("rt3_gap0", O_GAP); step();
    chk("rt3_rd1", O_RD);
    pulse(1'b0, 1'b0);
    chk("rt3_gap1", O_GAP); step();
    chk("rt3_rd2", O_RD);
    pulse(1'b0, 1'b0);
    chk("rt3_err", O_ERR); step();
    chk("rt3_idle", O_IDLE);

    // Timeout: ReadShared held 256 cycles, then error
    set_line(1'b0, 3'b000); accept(1'b0);
    step();
    chk("to_rd_enter", O_RD);
    for (int i = 1; i < 256; i++) begin
      step();
      chk("to_rd_hold", O_RD);
    end
    step();
    chk("to_err", O_ERR); step();
    chk("to_idle", O_IDLE);

    // Snoop stalls LOOKUP for 5 cycles
    set_line(1'b1, 3'b000); snoop_busy = 1'b1; accept(1'b1);
    chk("sn_lookup", O_LOOKUP);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("sn_stall", O_LOOKUP);
    end
    snoop_busy = 1'b0;
    step();
    chk("sn_cpuwr", O_CPUWR); step();
    chk("sn_resp", O_RESP); step();
    chk("sn_idle", O_IDLE);

    // Stray ace_done in IDLE is ignored
    pulse(1'b1, 1'b1);
    chk("stray_done", O_IDLE);

    // Asynchronous reset in the middle of WB_REQ
    set_line(1'b0, 3'b001); accept(1'b0);
    step();
    chk("rst_wb", O_WB);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", O_IDLE);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_idle", O_IDLE);

    // Recovery after reset
    set_line(1'b1, 3'b001); accept(1'b0);
    chk("rec_lookup", O_LOOKUP); step();
    chk("rec_resp", O_RESP); step();
    chk("rec_idle", O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
